// File: rtl/huffman_tree_ctrl.sv
// huffman_tree_ctrl: serial 8-symbol Huffman tree builder driving an external sort stage.
// Ports: clk/rst, in_valid/in_weight, sort_char_o/sort_weight_o/sort_char_i, out_valid/out_char/out_len/out_code.
module huffman_tree_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [4:0]  in_weight,
    output logic [31:0] sort_char_o,
    output logic [39:0] sort_weight_o,
    input  logic [31:0] sort_char_i,
    output logic        out_valid,
    output logic [3:0]  out_char,
    output logic [2:0]  out_len,
    output logic [6:0]  out_code
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MERGE, S_OUT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [4:0]  weight_q [16];
    logic [4:0]  weight_d [16];
    logic [7:0]  mask_q [16];
    logic [7:0]  mask_d [16];
    logic [6:0]  code_q [8];
    logic [6:0]  code_d [8];
    logic [2:0]  len_q [8];
    logic [2:0]  len_d [8];
    logic [31:0] sch_q, sch_d;
    logic [39:0] swt_q, swt_d;
    logic        ov_q, ov_d;
    logic [3:0]  och_q, och_d;
    logic [2:0]  olen_q, olen_d;
    logic [6:0]  ocode_q, ocode_d;

    // Merge-round helpers: a/b are the two smallest nodes returned by the sort stage.
    logic [3:0]  id_a, id_b, new_id, n_live;
    logic [4:0]  w_a, w_b, w_new;
    logic [5:0]  w_sum;
    logic [7:0]  m_a, m_b;
    logic [39:0] sci_ext;

    assign id_a    = sort_char_i[3:0];
    assign id_b    = sort_char_i[7:4];
    assign w_a     = (id_a == 4'hF) ? 5'd31 : weight_q[id_a];
    assign w_b     = (id_b == 4'hF) ? 5'd31 : weight_q[id_b];
    assign m_a     = mask_q[id_a];
    assign m_b     = mask_q[id_b];
    assign w_sum   = {1'b0, w_a} + {1'b0, w_b};
    assign w_new   = w_sum[5] ? 5'd31 : w_sum[4:0];
    assign new_id  = 4'd8 + {1'b0, cnt_q};
    assign n_live  = 4'd8 - {1'b0, cnt_q};
    // Padding-extended so slot j+2 is always in range.
    assign sci_ext = {8'hFF, sort_char_i};

    assign sort_char_o   = sch_q;
    assign sort_weight_o = swt_q;
    assign out_valid     = ov_q;
    assign out_char      = och_q;
    assign out_len       = olen_q;
    assign out_code      = ocode_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        weight_d = weight_q;
        mask_d   = mask_q;
        code_d   = code_q;
        len_d    = len_q;
        sch_d    = sch_q;
        swt_d    = swt_q;
        ov_d     = 1'b0;
        och_d    = 4'd0;
        olen_d   = 3'd0;
        ocode_d  = 7'd0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    weight_d[0] = in_weight;
                    for (int i = 0; i < 16; i++) begin
                        mask_d[i] = (i < 8) ? (8'b1 << i) : 8'd0;
                    end
                    for (int i = 0; i < 8; i++) begin
                        code_d[i] = 7'd0;
                        len_d[i]  = 3'd0;
                    end
                    cnt_d   = 3'd1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    weight_d[{1'b0, cnt_q}] = in_weight;
                    if (cnt_q == 3'd7) begin
                        sch_d   = 32'h7654_3210;
                        swt_d   = {in_weight, weight_q[6], weight_q[5],
                                   weight_q[4], weight_q[3], weight_q[2],
                                   weight_q[1], weight_q[0]};
                        cnt_d   = 3'd0;
                        state_d = S_MERGE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_MERGE: begin
                weight_d[new_id] = w_new;
                mask_d[new_id]   = m_a | m_b;
                for (int l = 0; l < 8; l++) begin
                    // New bit lands above the existing bits: it is nearer the root.
                    if (m_a[l]) begin
                        code_d[l][len_q[l]] = 1'b0;
                        len_d[l]            = len_q[l] + 3'd1;
                    end
                    if (m_b[l]) begin
                        code_d[l][len_q[l]] = 1'b1;
                        len_d[l]            = len_q[l] + 3'd1;
                    end
                end
                for (int j = 0; j < 8; j++) begin
                    if (j + 2 < int'(n_live)) begin
                        sch_d[4*j +: 4] = sci_ext[4*(j+2) +: 4];
                        swt_d[5*j +: 5] = (sci_ext[4*(j+2) +: 4] == 4'hF) ? 5'd31
                                        : weight_q[sci_ext[4*(j+2) +: 4]];
                    end else if (j + 2 == int'(n_live)) begin
                        sch_d[4*j +: 4] = new_id;
                        swt_d[5*j +: 5] = w_new;
                    end else begin
                        sch_d[4*j +: 4] = 4'hF;
                        swt_d[5*j +: 5] = 5'd31;
                    end
                end
                if (cnt_q == 3'd6) begin
                    ov_d    = 1'b1;
                    och_d   = 4'd0;
                    olen_d  = len_d[0];
                    ocode_d = code_d[0];
                    cnt_d   = 3'd0;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_OUT: begin
                if (cnt_q == 3'd7) begin
                    cnt_d   = 3'd0;
                    state_d = S_IDLE;
                end else begin
                    ov_d    = 1'b1;
                    och_d   = {1'b0, cnt_q + 3'd1};
                    olen_d  = len_q[cnt_q + 3'd1];
                    ocode_d = code_q[cnt_q + 3'd1];
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            for (int i = 0; i < 16; i++) begin
                weight_q[i] <= 5'd0;
                mask_q[i]   <= 8'd0;
            end
            for (int i = 0; i < 8; i++) begin
                code_q[i] <= 7'd0;
                len_q[i]  <= 3'd0;
            end
            sch_q   <= '1;
            swt_q   <= '1;
            ov_q    <= 1'b0;
            och_q   <= 4'd0;
            olen_q  <= 3'd0;
            ocode_q <= 7'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            weight_q <= weight_d;
            mask_q   <= mask_d;
            code_q   <= code_d;
            len_q    <= len_d;
            sch_q    <= sch_d;
            swt_q    <= swt_d;
            ov_q     <= ov_d;
            och_q    <= och_d;
            olen_q   <= olen_d;
            ocode_q  <= ocode_d;
        end
    end
endmodule
